// File: rtl/proxy_weight_loader_pkg.sv
// ============================================================================
//  Module      : proxy_weight_loader_pkg
//  Description : Shared state encoding and weight type for the proxy weight
//                loader and the chain registers it drives.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proxy_weight_loader_pkg;

    localparam int unsigned WORD_SIZE_DFLT = 16;

    typedef logic signed [WORD_SIZE_DFLT-1:0] weight_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/proxy_weight_loader.sv
// ============================================================================
//  Module      : proxy_weight_loader
//  Description : Buffers one column of weights (zeroing bypassed rows), then
//                shifts them farthest-row-first into a two-stage chain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proxy_weight_loader
    import proxy_weight_loader_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DFLT,
    parameter int CHAIN_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CHAIN_LEN-1:0]        row_bypass,
    input  logic signed [WORD_SIZE-1:0] wt_in,
    input  logic                        wt_valid,
    output logic                        wt_ready,
    input  logic                        stall,
    output logic signed [WORD_SIZE-1:0] chain_d,
    output logic                        shift_en,
    output logic                        busy,
    output logic                        done
);

    localparam int ROW_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int CNT_W = $clog2(2 * CHAIN_LEN);

    localparam logic [ROW_W-1:0] c_LAST_ROW   = ROW_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_LAST_SHIFT = CNT_W'(2 * CHAIN_LEN - 1);

    state_t                        r_state;
    logic [CHAIN_LEN-1:0]          r_mask;
    logic [ROW_W-1:0]              r_fill_row;
    logic [CNT_W-1:0]              r_shift_cnt;
    logic signed [WORD_SIZE-1:0]   r_buf [CHAIN_LEN];
    logic                          r_done;

    logic                          w_row_byp;
    logic [ROW_W-1:0]              w_rd_row;

    assign w_row_byp = r_mask[r_fill_row];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_fill_row  <= '0;
            r_shift_cnt <= '0;
            r_done      <= 1'b0;
            for (int i = 0; i < CHAIN_LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            // done appears the cycle after DONE so the next start can be taken with it
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask     <= row_bypass;
                        r_fill_row <= '0;
                        r_state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_row_byp || wt_valid) begin
                        r_buf[r_fill_row] <= w_row_byp ? '0 : wt_in;
                        if (r_fill_row == c_LAST_ROW) begin
                            r_shift_cnt <= '0;
                            r_state     <= ST_SHIFT;
                        end else begin
                            r_fill_row <= r_fill_row + 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!stall) begin
                        if (r_shift_cnt == c_LAST_SHIFT) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_shift_cnt <= r_shift_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Each buffered word is presented for two counted shifts: one per stage of its row.
    always_comb begin
        wt_ready = 1'b0;
        shift_en = 1'b0;
        chain_d  = '0;
        w_rd_row = c_LAST_ROW - ROW_W'(r_shift_cnt >> 1);
        if (r_state == ST_FILL) begin
            wt_ready = !w_row_byp;
        end
        if (r_state == ST_SHIFT) begin
            shift_en = 1'b1;
            chain_d  = r_buf[w_rd_row];
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_proxy_weight_loader.sv
// ============================================================================
//  Module      : tb_proxy_weight_loader
//  Description : Self-checking bench for proxy_weight_loader driving a
//                behavioural two-stage-per-row weight chain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proxy_weight_loader;
    import proxy_weight_loader_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N-1:0]    row_bypass;
    weight_t         wt_in;
    logic            wt_valid;
    logic            wt_ready;
    logic            stall;
    weight_t         chain_d;
    logic            shift_en;
    logic            busy;
    logic            done;

    int n_cmp = 0;
    int n_err = 0;

    weight_t src_q [$];
    weight_t chain [2*N];

    proxy_weight_loader #(.WORD_SIZE(W), .CHAIN_LEN(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .row_bypass (row_bypass),
        .wt_in      (wt_in),
        .wt_valid   (wt_valid),
        .wt_ready   (wt_ready),
        .stall      (stall),
        .chain_d    (chain_d),
        .shift_en   (shift_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Column load: chain[2i] is row i stalled_out stage, chain[2i+1] its Q stage.
    always_ff @(posedge clk) begin
        if (shift_en && !stall) begin
            chain[0] <= chain_d;
            for (int i = 1; i < 2*N; i++) chain[i] <= chain[i-1];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_load(input logic [N-1:0] mask, input int vmode,
                           input int stall_at, input int stall_len,
                           input bit pre, input bit sif, input bit sid,
                           input int abort_k, input int exp_done);
        weight_t exp_buf [N];
        int row, k, stalls_left, stalls, waits, act_xfers, cyc, phase, fill_cyc, exp_cyc;
        bit v;
        row = 0; k = 0; stalls_left = stall_len; stalls = 0; waits = 0;
        act_xfers = 0; phase = 0; fill_cyc = 0;
        if (!pre) @(negedge clk);
        start = 1'b1; row_bypass = mask; wt_valid = 1'b0; stall = 1'b0;
        @(negedge clk);
        cyc = 1;
        chk("done_cleared_on_start", done, 0);
        while (cyc < 400) begin
            start = 1'b0; wt_valid = 1'b0; stall = 1'b0;
            row_bypass = N'($urandom);
            case (phase)
                0: begin
                    chk("fill_busy", busy, 1);
                    chk("fill_shift_en", shift_en, 0);
                    chk("fill_done", done, 0);
                    chk("fill_wt_ready", wt_ready, int'(!mask[row]));
                    if (sif && fill_cyc == 1) begin
                        start = 1'b1; row_bypass = '1;
                    end
                    if (mask[row]) begin
                        wt_valid = 1'($urandom_range(0, 1));
                        wt_in = weight_t'($urandom);
                        exp_buf[row] = '0;
                        row++;
                    end else begin
                        case (vmode)
                            0:       v = 1'b1;
                            1:       v = (fill_cyc % 3 == 0);
                            default: v = 1'($urandom_range(0, 1));
                        endcase
                        wt_valid = v;
                        wt_in = v ? src_q[0] : weight_t'($urandom);
                        if (v) begin
                            exp_buf[row] = src_q.pop_front();
                            row++;
                        end else begin
                            waits++;
                        end
                    end
                    if (wt_valid && wt_ready) act_xfers++;
                    fill_cyc++;
                    if (row == N) phase = 1;
                end
                1: begin
                    chk("shift_en", shift_en, 1);
                    chk("shift_busy", busy, 1);
                    chk("chain_d", chain_d, exp_buf[N-1-k/2]);
                    if (k == abort_k) begin
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        chk("abort_shift_en", shift_en, 0);
                        chk("abort_chain_d", chain_d, 0);
                        chk("abort_busy", busy, 0);
                        chk("abort_done", done, 0);
                        repeat (2*N + 4) begin
                            @(negedge clk);
                            chk("abort_no_done", done, 0);
                            chk("abort_idle", busy, 0);
                        end
                        src_q.delete();
                        return;
                    end
                    if (k == stall_at && stalls_left > 0) begin
                        stall = 1'b1; stalls_left--; stalls++;
                    end else begin
                        k++;
                        if (k == 2*N) phase = 2;
                    end
                end
                2: begin
                    chk("donest_shift_en", shift_en, 0);
                    chk("donest_chain_d", chain_d, 0);
                    chk("donest_busy", busy, 1);
                    chk("donest_done", done, 0);
                    chk("donest_wt_ready", wt_ready, 0);
                    if (sid) begin
                        start = 1'b1; row_bypass = '1;
                    end
                    phase = 3;
                end
                default: begin
                    exp_cyc = (exp_done >= 0) ? exp_done : 2 + 3*N + waits + stalls;
                    chk("done_pulse", done, 1);
                    chk("done_busy", busy, 0);
                    chk("done_shift_en", shift_en, 0);
                    chk("done_cycle", cyc, exp_cyc);
                    chk("transfers", act_xfers, $countones(~mask));
                    for (int i = 0; i < N; i++) begin
                        chk($sformatf("row%0d_stalled", i), chain[2*i], exp_buf[i]);
                        chk($sformatf("row%0d_q", i), chain[2*i+1], exp_buf[i]);
                    end
                    src_q.delete();
                    return;
                end
            endcase
            @(negedge clk);
            cyc++;
        end
        n_cmp++; n_err++;
        $display("FAIL timeout: got %0d cycles expected completion", cyc);
        src_q.delete();
    endtask

    typedef struct {
        logic [N-1:0] mask;
        int vmode, stall_at, stall_len;
        bit pre, sif, sid;
        int exp_done;
        int w0, w1, w2, w3;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{4'b0000, 0, -1, 0, 1'b0, 1'b0, 1'b0, 14, 10, -20, 30, -40};
        vecs[1] = '{4'b0101, 0, -1, 0, 1'b0, 1'b0, 1'b0, 14, 7, 9, 0, 0};
        vecs[2] = '{4'b0000, 0,  3, 3, 1'b0, 1'b0, 1'b0, 17, 10, -20, 30, -40};
        vecs[3] = '{4'b0000, 1, -1, 0, 1'b0, 1'b0, 1'b0, 20, 10, -20, 30, -40};
        vecs[4] = '{4'b0000, 0, -1, 0, 1'b0, 1'b1, 1'b1, 14, 10, -20, 30, -40};
        vecs[5] = '{4'b1111, 0, -1, 0, 1'b1, 1'b0, 1'b0, 14, 0, 0, 0, 0};
        vecs[6] = '{4'b1010, 1, -1, 0, 1'b1, 1'b0, 1'b0, -1, -32768, 32767, 0, 0};

        for (int i = 0; i < 2*N; i++) chain[i] = '0;
        rst = 1'b1; start = 1'b0; row_bypass = '0; wt_in = '0; wt_valid = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wt_ready", wt_ready, 0);
        chk("rst_chain_d", chain_d, 0);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start_busy", busy, 0);

        for (int t = 0; t < 7; t++) begin
            src_q.push_back(weight_t'(vecs[t].w0));
            src_q.push_back(weight_t'(vecs[t].w1));
            src_q.push_back(weight_t'(vecs[t].w2));
            src_q.push_back(weight_t'(vecs[t].w3));
            do_load(vecs[t].mask, vecs[t].vmode, vecs[t].stall_at, vecs[t].stall_len,
                    vecs[t].pre, vecs[t].sif, vecs[t].sid, -1, vecs[t].exp_done);
        end

        // Reset while shift_cnt=5, then a fresh nominal load must complete
        src_q = '{weight_t'(10), weight_t'(-20), weight_t'(30), weight_t'(-40)};
        do_load(4'b0000, 0, -1, 0, 1'b0, 1'b0, 1'b0, 5, 14);
        src_q = '{weight_t'(10), weight_t'(-20), weight_t'(30), weight_t'(-40)};
        do_load(4'b0000, 0, -1, 0, 1'b0, 1'b0, 1'b0, -1, 14);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) src_q.push_back(weight_t'($urandom));
            do_load(N'($urandom), 2, $urandom_range(0, 2*N-1), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1, -1);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
